layer0_input_quantizer: RTL and testbench

// - Upstream feeder for the layer0 neuron LUT array: accepts a stream of signed readout samples,
//   one feature per beat, quantizes each to IN_BITS, packs NUM_FEATURES of them into one vector.
// - Holds the packed vector in an output register with valid/ready. Layer0 neurons tap

---
 rtl/layer0_input_quantizer.sv | 152 +++++++++++++++
 tb/tb_layer0_input_quantizer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer0_input_quantizer.sv
// layer0_input_quantizer
// Collects NUM_FEATURES signed samples (one per beat), quantizes each to IN_BITS
// with arithmetic shift + saturation, and presents the packed vector through a
// valid/ready output register. Collection of the next vector overlaps the drain
// of the current one, so back-to-back events flow at one beat per cycle.
// Optional build macro: QUANT_ROUND_EN selects round-half-up instead of floor.
module layer0_input_quantizer #(
    parameter int NUM_FEATURES = 8,
    parameter int SAMPLE_W     = 16,
    parameter int IN_BITS      = 2,
    parameter int SHIFT        = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [SAMPLE_W-1:0]             in_data,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_FEATURES*IN_BITS-1:0] out_vec,
    output logic                            frame_err
);

    localparam int VEC_W = NUM_FEATURES * IN_BITS;
    localparam int CNT_W = $clog2(NUM_FEATURES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_FEATURES - 1);
    localparam int QMAX_I = (1 << (IN_BITS - 1)) - 1;
    localparam logic signed [SAMPLE_W:0] QMAX = (SAMPLE_W + 1)'(QMAX_I);
    localparam logic signed [SAMPLE_W:0] QMIN = (SAMPLE_W + 1)'(-QMAX_I - 1);
`ifdef QUANT_ROUND_EN
    // Half of one output LSB; zero when SHIFT is zero, making rounding a no-op.
    localparam logic signed [SAMPLE_W:0] RND = (SAMPLE_W + 1)'((1 << SHIFT) >> 1);
`endif

    // Shift (optionally rounded) then clamp into the signed IN_BITS range.
    // One extra bit of headroom keeps the rounding add from wrapping at +max.
    function automatic logic [IN_BITS-1:0] quantize(input logic [SAMPLE_W-1:0] sample);
        logic signed [SAMPLE_W:0] wide;
        logic signed [SAMPLE_W:0] shifted;
        logic signed [SAMPLE_W:0] sat;
        wide = $signed({sample[SAMPLE_W-1], sample});
`ifdef QUANT_ROUND_EN
        wide = wide + RND;
`endif
        shifted = wide >>> SHIFT;
        if (shifted > QMAX) begin
            sat = QMAX;
        end else if (shifted < QMIN) begin
            sat = QMIN;
        end else begin
            sat = shifted;
        end
        return sat[IN_BITS-1:0];
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [VEC_W-1:0] buf_q, buf_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             drop_q, drop_d;

    logic             accept_s;
    logic             at_last_s;
    logic [IN_BITS-1:0] qval_s;
    logic [VEC_W-1:0] merged_s;

    // The final slot may only be taken when the output register is free or draining.
    assign in_ready  = (cnt_q != CNT_LAST) || !valid_q || out_ready;
    assign accept_s  = in_valid && in_ready;
    assign at_last_s = (cnt_q == CNT_LAST);
    assign qval_s    = quantize(in_data);

    assign out_vec   = vec_q;
    assign out_valid = valid_q;
    assign frame_err = err_q;

    // Collect buffer with the incoming quantized sample dropped into slot cnt.
    always_comb begin
        merged_s = buf_q;
        merged_s[cnt_q*IN_BITS +: IN_BITS] = qval_s;
    end

    // Next-state logic: collection counter, framing checks and output register.
    always_comb begin
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        vec_d   = vec_q;
        valid_d = valid_q;
        err_d   = err_q;
        drop_d  = drop_q;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if (accept_s) begin
            if (drop_q) begin
                // Discarding the tail of an over-long event up to its in_last.
                if (in_last) begin
                    drop_d = 1'b0;
                end else begin
                    drop_d = 1'b1;
                end
            end else if (at_last_s) begin
                cnt_d = '0;
                buf_d = '0;
                if (in_last) begin
                    vec_d   = merged_s;
                    valid_d = 1'b1;
                end else begin
                    err_d  = 1'b1;
                    drop_d = 1'b1;
                end
            end else begin
                if (in_last) begin
                    err_d = 1'b1;
                    cnt_d = '0;
                    buf_d = '0;
                end else begin
                    buf_d = merged_s;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset discards any partial or pending vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            buf_q   <= '0;
            vec_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            vec_q   <= vec_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_layer0_input_quantizer.sv
// Directed testbench for layer0_input_quantizer (default parameters).
module tb_layer0_input_quantizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0000;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_vec;
    logic        frame_err;

    int total = 0;
    int bad = 0;
    int stalls = 0;
    logic [15:0] outq[$];

    localparam logic [127:0] EV_BASIC = {16'hFE00, 16'h0180, 16'h00FF, 16'h0000,
                                         16'h8000, 16'h7FFF, 16'hFF00, 16'h0100};
    localparam logic [127:0] EV_ONES  = {8{16'h0100}};
    localparam logic [127:0] EV_NEG   = {8{16'hFF00}};
    localparam logic [127:0] EV_MIN   = {8{16'h8000}};
    localparam logic [127:0] EV_RND   = {16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                         16'h0000, 16'hFF80, 16'h007F, 16'h0080};
    localparam logic [15:0] EXP_ONES  = 16'h5555;
    localparam logic [15:0] EXP_NEG   = 16'hFFFF;
    localparam logic [15:0] EXP_MIN   = 16'hAAAA;
`ifdef QUANT_ROUND_EN
    localparam logic [15:0] EXP_BASIC = 16'h949D;
    localparam logic [15:0] EXP_RND   = 16'h0001;
`else
    localparam logic [15:0] EXP_BASIC = 16'h909D;
    localparam logic [15:0] EXP_RND   = 16'h0030;
`endif

    layer0_input_quantizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Record drained vectors and stalled beats half a cycle away from the active edge.
    always @(negedge clk) begin
        if (out_valid && out_ready) outq.push_back(out_vec);
        if (in_valid && !in_ready) stalls++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [15:0] d, input logic l);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        #1;
        while (!in_ready && waited < 100) begin
            @(posedge clk); #2;
            waited++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL beat_accept: in_ready=%b after %0d cycles, want 1", in_ready, waited);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_event(input logic [127:0] s, input logic hold);
        for (int k = 0; k < 8; k++) send_beat(s[k*16 +: 16], (k == 7));
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total++;
        if (out_valid !== 1'b0 || out_vec !== 16'h0000 || frame_err !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: valid=%b vec=%h err=%b rdy=%b, want 0 0000 0 1",
                     out_valid, out_vec, frame_err, in_ready);
        end
        apply_reset();
    endtask

    task automatic test_basic();
        out_ready = 1'b0;
        for (int k = 0; k < 7; k++) send_beat(EV_BASIC[k*16 +: 16], 1'b0);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_early_valid: got %b want 0", out_valid);
        end
        send_beat(EV_BASIC[127:112], 1'b1);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_vec !== EXP_BASIC) begin
            bad++;
            $display("FAIL basic_vec: valid=%b vec=%h, want 1 %h", out_valid, out_vec, EXP_BASIC);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_event(EV_ONES, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_vec !== EXP_ONES) begin
            bad++;
            $display("FAIL bp_first: valid=%b vec=%h, want 1 %h", out_valid, out_vec, EXP_ONES);
        end
        for (int k = 0; k < 7; k++) send_beat(EV_NEG[k*16 +: 16], 1'b0);
        in_valid = 1'b1;
        in_data  = 16'hFF00;
        in_last  = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_ready_low: in_ready=%b want 0", in_ready);
        end
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (out_valid !== 1'b1 || out_vec !== EXP_ONES || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold: valid=%b vec=%h rdy=%b, want 1 %h 0", out_valid, out_vec, in_ready, EXP_ONES);
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_vec !== EXP_NEG) begin
            bad++;
            $display("FAIL bp_second: valid=%b vec=%h, want 1 %h", out_valid, out_vec, EXP_NEG);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_drained: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        time t0;
        time t1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        outq.delete();
        stalls = 0;
        t0 = $time;
        send_event(EV_BASIC, 1'b1);
        send_event(EV_ONES, 1'b1);
        send_event(EV_MIN, 1'b0);
        t1 = $time;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ((t1 - t0) != 240 || stalls != 0) begin
            bad++;
            $display("FAIL b2b_rate: elapsed=%0t stalls=%0d, want 240 0", t1 - t0, stalls);
        end
        total++;
        if (outq.size() != 3) begin
            bad++;
            $display("FAIL b2b_count: got %0d vectors want 3", outq.size());
        end else if (outq[0] !== EXP_BASIC || outq[1] !== EXP_ONES || outq[2] !== EXP_MIN) begin
            bad++;
            $display("FAIL b2b_data: got %h %h %h want %h %h %h",
                     outq[0], outq[1], outq[2], EXP_BASIC, EXP_ONES, EXP_MIN);
        end
    endtask

    task automatic test_rounding();
        out_ready = 1'b1;
        outq.delete();
        send_event(EV_RND, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (outq.size() != 1 || outq[0] !== EXP_RND) begin
            bad++;
            $display("FAIL rounding: got n=%0d vec=%h want 1 %h", outq.size(),
                     (outq.size() > 0) ? outq[0] : 16'hxxxx, EXP_RND);
        end
    endtask

    task automatic test_framing();
        apply_reset();
        out_ready = 1'b1;
        outq.delete();
        for (int k = 0; k < 5; k++) send_beat(EV_ONES[k*16 +: 16], (k == 4));
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (frame_err !== 1'b1 || outq.size() != 0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL short_frame: err=%b n=%0d valid=%b want 1 0 0", frame_err, outq.size(), out_valid);
        end
        send_event(EV_BASIC, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (outq.size() != 1 || outq[0] !== EXP_BASIC || frame_err !== 1'b1) begin
            bad++;
            $display("FAIL short_recover: n=%0d vec=%h err=%b want 1 %h 1", outq.size(),
                     (outq.size() > 0) ? outq[0] : 16'hxxxx, frame_err, EXP_BASIC);
        end
    endtask

    task automatic test_long_frame();
        for (int r = 0; r < 2; r++) begin
            int len;
            len = (r == 0) ? 10 : 16;
            apply_reset();
            out_ready = 1'b1;
            outq.delete();
            for (int k = 0; k < len; k++) send_beat(16'h0100, (k == len - 1));
            in_valid = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            total++;
            if (frame_err !== 1'b1 || outq.size() != 0) begin
                bad++;
                $display("FAIL long_frame_%0d: err=%b n=%0d want 1 0", len, frame_err, outq.size());
            end
            send_event(EV_NEG, 1'b0);
            repeat (2) @(posedge clk);
            #1;
            total++;
            if (outq.size() != 1 || outq[0] !== EXP_NEG) begin
                bad++;
                $display("FAIL long_recover_%0d: n=%0d vec=%h want 1 %h", len, outq.size(),
                         (outq.size() > 0) ? outq[0] : 16'hxxxx, EXP_NEG);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        out_ready = 1'b0;
        send_event(EV_ONES, 1'b0);
        for (int k = 0; k < 4; k++) send_beat(EV_NEG[k*16 +: 16], 1'b0);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre: valid=%b want 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_vec !== 16'h0000 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: valid=%b vec=%h err=%b want 0 0000 0", out_valid, out_vec, frame_err);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        outq.delete();
        send_event(EV_BASIC, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (outq.size() != 1 || outq[0] !== EXP_BASIC || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL rst_fresh: n=%0d vec=%h err=%b want 1 %h 0", outq.size(),
                     (outq.size() > 0) ? outq[0] : 16'hxxxx, frame_err, EXP_BASIC);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_rounding();
        test_framing();
        test_long_frame();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
